// File: rtl/ff_rd_status_if.sv
// ---------------------------------------------------------------------------
// ff_rd_status_if
// Bundle of read-side FIFO status signals between the read-domain status
// stage and its neighbours (read gray counter, consumer, write pointer).
//   wptr_gry_async : write gray pointer, asynchronous to the read clock
//   rptr_gry       : current read gray pointer (read counter gry_cnt)
//   rptr_gry_nxt   : next read gray pointer (read counter gry_cnt_nxt)
//   rd_req         : consumer read request
//   underflow_clr  : clears the sticky underflow flag
//   rd_en          : accepted read (read counter en / RAM read strobe)
//   empty          : FIFO empty, registered
//   almost_empty   : occupancy at or below threshold, registered
//   occ            : occupancy in words, registered
//   underflow      : sticky read-while-empty flag
//   wptr_gry_sync  : last synchroniser stage (monitor)
// Modports: master = surrounding logic, slave = status stage.
// ---------------------------------------------------------------------------
interface ff_rd_status_if #(
  parameter int unsigned PTR_W = 4
);
  logic [PTR_W-1:0] wptr_gry_async;
  logic [PTR_W-1:0] rptr_gry;
  logic [PTR_W-1:0] rptr_gry_nxt;
  logic             rd_req;
  logic             underflow_clr;
  logic             rd_en;
  logic             empty;
  logic             almost_empty;
  logic [PTR_W-1:0] occ;
  logic             underflow;
  logic [PTR_W-1:0] wptr_gry_sync;

  modport master (
    output wptr_gry_async, rptr_gry, rptr_gry_nxt, rd_req, underflow_clr,
    input  rd_en, empty, almost_empty, occ, underflow, wptr_gry_sync
  );

  modport slave (
    input  wptr_gry_async, rptr_gry, rptr_gry_nxt, rd_req, underflow_clr,
    output rd_en, empty, almost_empty, occ, underflow, wptr_gry_sync
  );
endinterface

// File: rtl/ff_rd_status.sv
// ---------------------------------------------------------------------------
// ff_rd_status
// Read-side status stage of the async FIFO. Synchronises the write gray
// pointer into the read clock, compares it with the next read pointer and
// registers empty / almost_empty / occupancy / sticky underflow. Gates the
// consumer read request into the read-counter enable.
// Ports:
//   clk   : read-domain clock
//   rst_n : asynchronous active-low reset
//   bus   : ff_rd_status_if.slave (pointers, request, status outputs)
// Parameters:
//   ADDR_W      : FIFO address width, pointers carry one extra wrap bit
//   SYNC_STAGES : write-pointer synchroniser depth (2..4)
//   AE_THRESH   : almost_empty when occupancy <= AE_THRESH (0..2^ADDR_W)
// ---------------------------------------------------------------------------
module ff_rd_status #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ff_rd_status_if.slave       bus
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  // Gray -> binary: bin[i] = ^gry[PTR_W-1:i]
  function automatic logic [PTR_W-1:0] gry2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_W-1:0] bin2gry(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
  logic                              empty_q;
  logic                              almost_empty_q;
  logic [PTR_W-1:0]                  occ_q;
  logic                              underflow_q;

  logic [PTR_W-1:0] wptr_sync;
  logic [PTR_W-1:0] wbin_sync;
  logic [PTR_W-1:0] rbin_nxt;
  logic [PTR_W-1:0] occ_nxt;
  logic             empty_nxt;
  logic             almost_empty_nxt;
  logic             underflow_set;

  // Plain flop chain, no logic between stages; gray coding keeps each
  // sampled value at most one step away from a legal pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.wptr_gry_async};
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];

  // Status is computed from the pointer after this cycle's read, so a read
  // shows up in empty/occ on the same edge that advances the read counter.
  always_comb begin
    wbin_sync        = gry2bin(wptr_sync);
    rbin_nxt         = gry2bin(bus.rptr_gry_nxt);
    occ_nxt          = wbin_sync - rbin_nxt;
    empty_nxt        = (bus.rptr_gry_nxt == wptr_sync);
    almost_empty_nxt = (occ_nxt <= PTR_W'(AE_THRESH));
    underflow_set    = bus.rd_req & empty_q;
  end

  // Registered status flags; reset shows an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      occ_q          <= '0;
    end else begin
      empty_q        <= empty_nxt;
      almost_empty_q <= almost_empty_nxt;
      occ_q          <= occ_nxt;
    end
  end

  // Sticky underflow; a new underflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (underflow_set) begin
      underflow_q <= 1'b1;
    end else if (bus.underflow_clr) begin
      underflow_q <= 1'b0;
    end
  end

  assign bus.rd_en         = bus.rd_req & ~empty_q;
  assign bus.empty         = empty_q;
  assign bus.almost_empty  = almost_empty_q;
  assign bus.occ           = occ_q;
  assign bus.underflow     = underflow_q;
  assign bus.wptr_gry_sync = wptr_sync;

  // The read counter may only hold or take one gray step per cycle.
  logic [PTR_W-1:0] rptr_succ;
  assign rptr_succ = bin2gry(gry2bin(bus.rptr_gry) + PTR_W'(1));

  a_rptr_step: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rptr_gry_nxt == bus.rptr_gry) || (bus.rptr_gry_nxt == rptr_succ))
    else $error("ff_rd_status: rptr_gry_nxt is not rptr_gry or its gray successor");

endmodule
